// File: rtl/dadda_pkg.sv
// Shared constants for the Dadda multiplier: reduction height sequence and
// carry-select segment widths.
package dadda_pkg;

  localparam int unsigned NumSeg = 3;

  // k-th term of 2, 3, 4, 6, 9, 13, ...
  function automatic int unsigned dadda_d(int unsigned k);
    int unsigned d;
    d = 2;
    for (int unsigned i = 0; i < k; i++) begin
      d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction stages needed for a tallest column of height h.
  function automatic int unsigned dadda_num_stages(int unsigned h);
    int unsigned n;
    n = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (dadda_d(k) < h) n++;
    end
    return n;
  endfunction

  // Lower segments take the extra bits when total is not a multiple of NumSeg.
  function automatic int unsigned seg_width(int unsigned total, int unsigned idx);
    return total / NumSeg + ((idx < total % NumSeg) ? 1 : 0);
  endfunction

  function automatic int unsigned seg_lo(int unsigned total, int unsigned idx);
    int unsigned lo;
    lo = 0;
    for (int unsigned i = 0; i < idx; i++) begin
      lo += seg_width(total, i);
    end
    return lo;
  endfunction

endpackage

// File: rtl/dadda_csel_adder.sv
// Three-segment carry-select adder; result is the sum modulo 2^W.
module dadda_csel_adder
  import dadda_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  logic [NumSeg-1:0] w_carry;

  assign w_carry[0] = 1'b0;

  for (genvar g = 0; g < NumSeg; g++) begin : g_seg
    localparam int unsigned Lo = seg_lo(W, g);
    localparam int unsigned Sw = seg_width(W, g);

    logic [Sw:0] w_s0;
    logic [Sw:0] w_s1;

    // Both carry-in hypotheses are computed; the incoming carry only selects.
    assign w_s0 = {1'b0, i_a[Lo +: Sw]} + {1'b0, i_b[Lo +: Sw]};
    assign w_s1 = {1'b0, i_a[Lo +: Sw]} + {1'b0, i_b[Lo +: Sw]} + {{Sw{1'b0}}, 1'b1};

    assign o_sum[Lo +: Sw] = w_carry[g] ? w_s1[Sw-1:0] : w_s0[Sw-1:0];

    if (g < NumSeg - 1) begin : g_cout
      assign w_carry[g+1] = w_carry[g] ? w_s1[Sw] : w_s0[Sw];
    end
  end

endmodule

// File: rtl/dadda_mult_pipe.sv
// Three-stage pipelined Dadda multiplier, signed (Baugh-Wooley) or unsigned per
// transaction, with a tag carried alongside and a ready/valid handshake.
module dadda_mult_pipe
  import dadda_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int unsigned NCol   = 2 * WIDTH;
  localparam int unsigned MaxH   = WIDTH;
  localparam int unsigned NStage = dadda_num_stages(MaxH);

  logic               r_v1, r_v2, r_v3;
  logic [WIDTH-1:0]   r_a1, r_b1;
  logic               r_sgn1;
  logic [TAG_W-1:0]   r_tag1, r_tag2, r_tag3;
  logic [NCol-1:0]    r_row0, r_row1, r_res3;

  logic               w_adv;
  logic [NCol-1:0]    w_row0, w_row1, w_sum;

  // The whole pipe moves together; it only stalls when the output is blocked.
  assign w_adv     = !r_v3 || out_ready;
  assign in_ready  = rst || w_adv;
  assign out_valid = r_v3;
  assign result    = r_res3;
  assign out_tag   = r_tag3;

  always_comb begin : b_reduce
    logic [MaxH-1:0]  cur   [NCol+1];
    logic [MaxH-1:0]  nxt   [NCol+1];
    int unsigned      cur_h [NCol+1];
    int unsigned      nxt_h [NCol+1];
    logic [MaxH-1:0]  x;
    int unsigned      tot, idx, d;
    logic             pp, fs, fc;

    for (int c = 0; c <= int'(NCol); c++) begin
      cur[c]   = '0;
      nxt[c]   = '0;
      cur_h[c] = 0;
      nxt_h[c] = 0;
    end
    x      = '0;
    tot    = 0;
    idx    = 0;
    d      = 0;
    pp     = 1'b0;
    fs     = 1'b0;
    fc     = 1'b0;
    w_row0 = '0;
    w_row1 = '0;

    // Baugh-Wooley: invert MSB row/column bits except the corner.
    for (int i = 0; i < int'(WIDTH); i++) begin
      for (int j = 0; j < int'(WIDTH); j++) begin
        pp = r_a1[j] & r_b1[i];
        if (r_sgn1 && ((i == int'(WIDTH) - 1) != (j == int'(WIDTH) - 1))) pp = ~pp;
        cur[i+j]   = cur[i+j] | (MaxH'(pp) << cur_h[i+j]);
        cur_h[i+j] = cur_h[i+j] + 1;
      end
    end
    if (r_sgn1) begin
      cur[WIDTH]     = cur[WIDTH] | (MaxH'(1'b1) << cur_h[WIDTH]);
      cur_h[WIDTH]   = cur_h[WIDTH] + 1;
      cur[NCol-1]    = cur[NCol-1] | (MaxH'(1'b1) << cur_h[NCol-1]);
      cur_h[NCol-1]  = cur_h[NCol-1] + 1;
    end

    for (int s = int'(NStage) - 1; s >= 0; s--) begin
      d = dadda_d(s);
      for (int c = 0; c <= int'(NCol); c++) begin
        nxt[c]   = '0;
        nxt_h[c] = 0;
      end
      for (int c = 0; c < int'(NCol); c++) begin
        idx = 0;
        // Carries already deposited from column c-1 count toward the target.
        tot = cur_h[c] + nxt_h[c];
        for (int k = 0; k < int'(MaxH); k++) begin
          if (tot > d) begin
            x = cur[c] >> idx;
            if (tot - d >= 2) begin
              fs  = x[0] ^ x[1] ^ x[2];
              fc  = (x[0] & x[1]) | (x[0] & x[2]) | (x[1] & x[2]);
              idx = idx + 3;
              tot = tot - 2;
            end else begin
              fs  = x[0] ^ x[1];
              fc  = x[0] & x[1];
              idx = idx + 2;
              tot = tot - 1;
            end
            nxt[c]     = nxt[c] | (MaxH'(fs) << nxt_h[c]);
            nxt_h[c]   = nxt_h[c] + 1;
            nxt[c+1]   = nxt[c+1] | (MaxH'(fc) << nxt_h[c+1]);
            nxt_h[c+1] = nxt_h[c+1] + 1;
          end
        end
        nxt[c]   = nxt[c] | ((cur[c] >> idx) << nxt_h[c]);
        nxt_h[c] = nxt_h[c] + cur_h[c] - idx;
      end
      for (int c = 0; c <= int'(NCol); c++) begin
        cur[c]   = nxt[c];
        cur_h[c] = nxt_h[c];
      end
    end

    for (int c = 0; c < int'(NCol); c++) begin
      w_row0[c] = cur[c][0];
      w_row1[c] = cur[c][1];
    end
  end

  dadda_csel_adder #(
    .W (NCol)
  ) u_adder (
    .i_a   (r_row0),
    .i_b   (r_row1),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_v2   <= 1'b0;
      r_v3   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sgn1 <= 1'b0;
      r_tag1 <= '0;
      r_tag2 <= '0;
      r_tag3 <= '0;
      r_row0 <= '0;
      r_row1 <= '0;
      r_res3 <= '0;
    end else if (w_adv) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      if (in_valid) begin
        r_a1   <= a;
        r_b1   <= b;
        r_sgn1 <= is_signed;
        r_tag1 <= in_tag;
      end
      if (r_v1) begin
        r_row0 <= w_row0;
        r_row1 <= w_row1;
        r_tag2 <= r_tag1;
      end
      if (r_v2) begin
        r_res3 <= w_sum;
        r_tag3 <= r_tag2;
      end
    end
  end

endmodule
